// File: rtl/cv32e41s_rvfi_data_obi_tracker.sv
// RVFI data-side OBI tracker: pairs in-order OBI responses with their granted requests.
// Optional per-entry grant-to-rvalid latency counters: define CV32E41S_RVFI_OBI_LATENCY_EN.
`timescale 1ns/1ps

module cv32e41s_rvfi_data_obi_tracker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_i,
  input  logic                         gnt_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic                         we_i,
  input  logic [DATA_WIDTH/8-1:0]      be_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic                         rvalid_i,
  input  logic [DATA_WIDTH-1:0]        rdata_i,
  input  logic                         err_i,
  output logic                         trans_valid_o,
  output logic [ADDR_WIDTH-1:0]        trans_addr_o,
  output logic                         trans_we_o,
  output logic [DATA_WIDTH/8-1:0]      trans_be_o,
  output logic [DATA_WIDTH-1:0]        trans_wdata_o,
  output logic [DATA_WIDTH-1:0]        trans_rdata_o,
  output logic                         trans_err_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         overflow_o,
  output logic                         orphan_o
`ifdef CV32E41S_RVFI_OBI_LATENCY_EN
  ,
  output logic [15:0]                  trans_latency_o
`endif
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFS_W = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);

  // FIFO storage (no reset needed: occupancy is tracked by count_q)
  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
  logic                  we_mem    [DEPTH];
  logic [BE_W-1:0]       be_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, orphan_q;

  logic push, pop, push_ok, empty, full;

  logic                  trans_valid_q;
  logic [ADDR_WIDTH-1:0] trans_addr_q;
  logic                  trans_we_q;
  logic [BE_W-1:0]       trans_be_q;
  logic [DATA_WIDTH-1:0] trans_wdata_q, trans_rdata_q;
  logic                  trans_err_q;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_we;
  logic [BE_W-1:0]       rd_be;
  logic [DATA_WIDTH-1:0] rd_wdata;
  logic [OFS_W-1:0]      ofs;
  logic [BE_W-1:0]       be_rot;
  logic [DATA_WIDTH-1:0] wdata_rot, rdata_rot;

  function automatic logic [DATA_WIDTH-1:0] rotr_bytes(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [OFS_W-1:0]      k);
    int unsigned sh;
    sh = 8 * int'(k);
    // A shift by DATA_WIDTH yields zero, so k == 0 degenerates to d.
    return (d >> sh) | (d << (DATA_WIDTH - sh));
  endfunction

  assign push    = req_i & gnt_i;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign pop     = rvalid_i & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push & (~full | pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (rvalid_i && empty) begin
        orphan_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr_q]  <= addr_i;
      we_mem[wr_ptr_q]    <= we_i;
      be_mem[wr_ptr_q]    <= be_i;
      wdata_mem[wr_ptr_q] <= wdata_i;
    end
  end

  always_comb begin
    rd_addr   = addr_mem[rd_ptr_q];
    rd_we     = we_mem[rd_ptr_q];
    rd_be     = be_mem[rd_ptr_q];
    rd_wdata  = wdata_mem[rd_ptr_q];
    ofs       = rd_addr[OFS_W-1:0];
    be_rot    = rd_be >> ofs;
    wdata_rot = rd_we ? rotr_bytes(rd_wdata, ofs) : '0;
    rdata_rot = rotr_bytes(rdata_i, ofs);
    for (int j = 0; j < BE_W; j++) begin
      if (!be_rot[j]) begin
        rdata_rot[8*j +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trans_valid_q <= 1'b0;
      trans_addr_q  <= '0;
      trans_we_q    <= 1'b0;
      trans_be_q    <= '0;
      trans_wdata_q <= '0;
      trans_rdata_q <= '0;
      trans_err_q   <= 1'b0;
    end else begin
      trans_valid_q <= pop;
      if (pop) begin
        trans_addr_q  <= rd_addr;
        trans_we_q    <= rd_we;
        trans_be_q    <= be_rot;
        trans_wdata_q <= wdata_rot;
        trans_rdata_q <= rdata_rot;
        trans_err_q   <= err_i;
      end
    end
  end

`ifdef CV32E41S_RVFI_OBI_LATENCY_EN
  logic [15:0] lat_mem [DEPTH];
  logic [15:0] lat_q;
  logic [15:0] lat_pop;

  // Counters of free slots also run; they are cleared when the slot is pushed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (wr_ptr_q == PTR_W'(i))) begin
        lat_mem[i] <= '0;
      end else if (lat_mem[i] != 16'hFFFF) begin
        lat_mem[i] <= lat_mem[i] + 16'd1;
      end
    end
  end

  // The counter lags the grant by one cycle; add it back at pop time.
  assign lat_pop = (lat_mem[rd_ptr_q] == 16'hFFFF) ? 16'hFFFF : lat_mem[rd_ptr_q] + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q <= '0;
    end else if (pop) begin
      lat_q <= lat_pop;
    end
  end

  assign trans_latency_o = lat_q;
`endif

  assign trans_valid_o = trans_valid_q;
  assign trans_addr_o  = trans_addr_q;
  assign trans_we_o    = trans_we_q;
  assign trans_be_o    = trans_be_q;
  assign trans_wdata_o = trans_wdata_q;
  assign trans_rdata_o = trans_rdata_q;
  assign trans_err_o   = trans_err_q;
  assign outstanding_o = count_q;
  assign overflow_o    = overflow_q;
  assign orphan_o      = orphan_q;

endmodule

// File: tb/tb_cv32e41s_rvfi_data_obi_tracker.sv
// Scoreboard bench for cv32e41s_rvfi_data_obi_tracker (DATA_WIDTH=32, DEPTH=2).
`timescale 1ns/1ps

module tb_cv32e41s_rvfi_data_obi_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, gnt = 1'b0, we = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic [3:0]  be = '0;

  logic        trans_valid, trans_we, trans_err, overflow, orphan;
  logic [31:0] trans_addr, trans_wdata, trans_rdata;
  logic [3:0]  trans_be;
  logic [1:0]  outstanding;
`ifdef CV32E41S_RVFI_OBI_LATENCY_EN
  logic [15:0] trans_latency;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] lat;  // 0 = not checked
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cv32e41s_rvfi_data_obi_tracker #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .gnt_i        (gnt),
    .addr_i       (addr),
    .we_i         (we),
    .be_i         (be),
    .wdata_i      (wdata),
    .rvalid_i     (rvalid),
    .rdata_i      (rdata),
    .err_i        (err),
    .trans_valid_o(trans_valid),
    .trans_addr_o (trans_addr),
    .trans_we_o   (trans_we),
    .trans_be_o   (trans_be),
    .trans_wdata_o(trans_wdata),
    .trans_rdata_o(trans_rdata),
    .trans_err_o  (trans_err),
    .outstanding_o(outstanding),
    .overflow_o   (overflow),
    .orphan_o     (orphan)
`ifdef CV32E41S_RVFI_OBI_LATENCY_EN
    ,
    .trans_latency_o(trans_latency)
`endif
  );

  // Reference: output byte j comes from input byte (j+k) mod 4; enables shift down.
  function automatic rec_t model(input logic [31:0] a, input logic w, input logic [3:0] b,
                                 input logic [31:0] d, input logic [31:0] rd, input logic e);
    rec_t r;
    int   k;
    int   s;
    k       = int'(a[1:0]);
    r.addr  = a;
    r.we    = w;
    r.err   = e;
    r.lat   = '0;
    r.be    = '0;
    r.wdata = '0;
    r.rdata = '0;
    for (int j = 0; j < 4; j++) begin
      s = (j + k) % 4;
      if (j + k < 4) r.be[j] = b[j+k];
      if (w) r.wdata[8*j +: 8] = d[8*s +: 8];
      if (r.be[j]) r.rdata[8*j +: 8] = rd[8*s +: 8];
    end
    return r;
  endfunction

  // Record checker: every trans_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    rec_t e;
    logic bad;
    if (trans_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_record: got addr=%h we=%b rdata=%h, required no record",
                 trans_addr, trans_we, trans_rdata);
      end else begin
        e   = exp_q.pop_front();
        bad = (trans_addr !== e.addr) || (trans_we !== e.we) || (trans_be !== e.be) ||
              (trans_wdata !== e.wdata) || (trans_rdata !== e.rdata) || (trans_err !== e.err);
`ifdef CV32E41S_RVFI_OBI_LATENCY_EN
        if (e.lat != 0 && trans_latency !== e.lat) bad = 1'b1;
`endif
        if (bad) begin
          n_bad++;
          $display("FAIL record: got addr=%h we=%b be=%b wdata=%h rdata=%h err=%b, required addr=%h we=%b be=%b wdata=%h rdata=%h err=%b",
                   trans_addr, trans_we, trans_be, trans_wdata, trans_rdata, trans_err,
                   e.addr, e.we, e.be, e.wdata, e.rdata, e.err);
        end
      end
    end
  end

  task automatic drive_idle();
    req = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic grant(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    req = 1'b1; gnt = 1'b1; addr = a; we = w; be = b; wdata = d;
  endtask

  task automatic respond(input logic [31:0] rd, input logic e);
    rvalid = 1'b1; rdata = rd; err = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (trans_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b, required 0", trans_valid);
    end
    n_cmp++;
    if (outstanding !== 2'd0) begin
      n_bad++; $display("FAIL reset_outstanding: got %0d, required 0", outstanding);
    end
    n_cmp++;
    if ({overflow, orphan} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags: got %b, required 00", {overflow, orphan});
    end
    n_cmp++;
    if ({trans_addr, trans_wdata, trans_rdata, trans_be, trans_we, trans_err} !== '0) begin
      n_bad++; $display("FAIL reset_fields: got addr=%h wdata=%h rdata=%h, required zeros",
                        trans_addr, trans_wdata, trans_rdata);
    end
  endtask

  task automatic test_write();
    rec_t r;
    grant(32'h1002, 1'b1, 4'b1100, 32'hBBAA0000);
    tick();
    n_cmp++;
    if (outstanding !== 2'd1) begin
      n_bad++; $display("FAIL write_outstanding: got %0d, required 1", outstanding);
    end
    respond(32'h0, 1'b0);
    r = model(32'h1002, 1'b1, 4'b1100, 32'hBBAA0000, 32'h0, 1'b0);
    r.lat = 16'd1;
    exp_q.push_back(r);
    tick();
    n_cmp++;
    if (trans_wdata !== 32'h0000BBAA || trans_be !== 4'b0011 || trans_we !== 1'b1) begin
      n_bad++; $display("FAIL write_align: got wdata=%h be=%b we=%b, required 0000bbaa 0011 1",
                        trans_wdata, trans_be, trans_we);
    end
  endtask

  task automatic test_read();
    grant(32'h2001, 1'b0, 4'b0010, 32'hCAFEF00D);
    tick();
    respond(32'h11223344, 1'b0);
    exp_q.push_back(model(32'h2001, 1'b0, 4'b0010, 32'hCAFEF00D, 32'h11223344, 1'b0));
    tick();
    n_cmp++;
    if (trans_rdata !== 32'h00000033 || trans_wdata !== 32'h0 || trans_err !== 1'b0) begin
      n_bad++; $display("FAIL read_align: got rdata=%h wdata=%h err=%b, required 00000033 0 0",
                        trans_rdata, trans_wdata, trans_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_out [5];
    logic [1:0] got_out [5];
    exp_out = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    grant(32'h100, 1'b0, 4'hF, 32'h0);
    tick(); got_out[0] = outstanding;
    grant(32'h105, 1'b0, 4'hE, 32'h0);
    tick(); got_out[1] = outstanding;
    grant(32'h10B, 1'b1, 4'h8, 32'h77000000);
    respond(32'hA1A2A3A4, 1'b0);
    exp_q.push_back(model(32'h100, 1'b0, 4'hF, 32'h0, 32'hA1A2A3A4, 1'b0));
    tick(); got_out[2] = outstanding;
    respond(32'hB1B2B3B4, 1'b0);
    exp_q.push_back(model(32'h105, 1'b0, 4'hE, 32'h0, 32'hB1B2B3B4, 1'b0));
    tick(); got_out[3] = outstanding;
    respond(32'hC1C2C3C4, 1'b0);
    exp_q.push_back(model(32'h10B, 1'b1, 4'h8, 32'h77000000, 32'hC1C2C3C4, 1'b0));
    tick(); got_out[4] = outstanding;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got_out[i] !== exp_out[i]) begin
        n_bad++; $display("FAIL b2b_outstanding[%0d]: got %0d, required %0d",
                          i, got_out[i], exp_out[i]);
      end
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL b2b_overflow: got %b, required 0", overflow);
    end
  endtask

  task automatic test_overflow();
    grant(32'h200, 1'b0, 4'hF, 32'h0); tick();
    grant(32'h204, 1'b0, 4'hF, 32'h0); tick();
    grant(32'h208, 1'b0, 4'hF, 32'h0); tick();
    n_cmp++;
    if (overflow !== 1'b1 || outstanding !== 2'd2) begin
      n_bad++; $display("FAIL overflow_set: got ovf=%b out=%0d, required 1 2",
                        overflow, outstanding);
    end
    respond(32'h01020304, 1'b0);
    exp_q.push_back(model(32'h200, 1'b0, 4'hF, 32'h0, 32'h01020304, 1'b0));
    tick();
    respond(32'h05060708, 1'b0);
    exp_q.push_back(model(32'h204, 1'b0, 4'hF, 32'h0, 32'h05060708, 1'b0));
    tick();
    repeat (3) tick();
    n_cmp++;
    if (overflow !== 1'b1 || outstanding !== 2'd0) begin
      n_bad++; $display("FAIL overflow_sticky: got ovf=%b out=%0d, required 1 0",
                        overflow, outstanding);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_orphan_and_reset();
    respond(32'h55555555, 1'b0);
    tick();
    n_cmp++;
    if (orphan !== 1'b1 || trans_valid !== 1'b0 || outstanding !== 2'd0) begin
      n_bad++; $display("FAIL orphan_set: got orphan=%b valid=%b out=%0d, required 1 0 0",
                        orphan, trans_valid, outstanding);
    end
    // Same-cycle grant must not satisfy the response.
    grant(32'h300, 1'b0, 4'hF, 32'h0);
    respond(32'h66666666, 1'b0);
    tick();
    n_cmp++;
    if (outstanding !== 2'd1 || trans_valid !== 1'b0) begin
      n_bad++; $display("FAIL orphan_same_cycle: got out=%0d valid=%b, required 1 0",
                        outstanding, trans_valid);
    end
    grant(32'h304, 1'b0, 4'hF, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (outstanding !== 2'd0 || overflow !== 1'b0 || orphan !== 1'b0 || trans_valid !== 1'b0)
    begin
      n_bad++; $display("FAIL mid_reset: got out=%0d ovf=%b orphan=%b valid=%b, required 0 0 0 0",
                        outstanding, overflow, orphan, trans_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_err_write();
    grant(32'h3000, 1'b1, 4'hF, 32'hDEADBEEF);
    tick();
    respond(32'h0, 1'b1);
    exp_q.push_back(model(32'h3000, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1));
    tick();
    n_cmp++;
    if (trans_err !== 1'b1 || trans_wdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL err_write: got err=%b wdata=%h, required 1 deadbeef",
                        trans_err, trans_wdata);
    end
  endtask

  task automatic test_align();
    logic [31:0] a, d, rd;
    logic [3:0]  b;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 2; w++) begin
        a  = 32'h400 + 32'(k);
        b  = 4'($urandom_range(1, 15));
        d  = $urandom;
        rd = $urandom;
        grant(a, w[0], b, d);
        tick();
        respond(rd, 1'b0);
        exp_q.push_back(model(a, w[0], b, d, rd, 1'b0));
        tick();
      end
    end
  endtask

`ifdef CV32E41S_RVFI_OBI_LATENCY_EN
  task automatic test_latency();
    rec_t r;
    grant(32'h500, 1'b0, 4'hF, 32'h0);
    tick();
    repeat (4) tick();
    respond(32'h12345678, 1'b0);
    r     = model(32'h500, 1'b0, 4'hF, 32'h0, 32'h12345678, 1'b0);
    r.lat = 16'd5;
    exp_q.push_back(r);
    tick();
    n_cmp++;
    if (trans_latency !== 16'd5) begin
      n_bad++; $display("FAIL latency: got %0d, required 5", trans_latency);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_overflow();
    test_orphan_and_reset();
    test_err_write();
    test_align();
`ifdef CV32E41S_RVFI_OBI_LATENCY_EN
    test_latency();
`endif
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL pending_records: got %0d still expected, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
